// File: rtl/crossbar_arbiter_if.sv
// Control/status bundle between the crossbar arbiter (master) and the FIFO/mux/output-RAM datapath (slave).
interface crossbar_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        fifo_empty;
    logic [DATA_W-1:0] fifo_q1;
    logic [DATA_W-1:0] fifo_q2;
    logic [DATA_W-1:0] fifo_q3;
    logic [2:0]        out_full;
    logic [2:0]        fifo_rd;
    logic [2:0]        out_wr;
    logic [1:0]        mux_sel1;
    logic [1:0]        mux_sel2;
    logic [1:0]        mux_sel3;
    logic [2:0]        pkt_done;
    logic [7:0]        drop_cnt;

    modport master (
        input  fifo_empty, fifo_q1, fifo_q2, fifo_q3, out_full,
        output fifo_rd, out_wr, mux_sel1, mux_sel2, mux_sel3, pkt_done, drop_cnt
    );

    modport slave (
        output fifo_empty, fifo_q1, fifo_q2, fifo_q3, out_full,
        input  fifo_rd, out_wr, mux_sel1, mux_sel2, mux_sel3, pkt_done, drop_cnt
    );
endinterface

// File: rtl/crossbar_arbiter.sv
// 3x3 packet crossbar sequencer: round-robin grant per output, grant held for a whole packet, dest-0 packets dropped.
// Grant registers one cycle after the header appears; strobes are combinational from state and stall on empty/full.
module crossbar_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LEN_LSB = 2,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    crossbar_arbiter_if.master bus
);
    typedef enum logic [1:0] {IN_IDLE, IN_FWD, IN_DROP} in_st_e;
    typedef enum logic       {OUT_IDLE, OUT_BUSY}        out_st_e;

    if (LEN_LSB + LEN_W > DATA_W) begin : g_len_field_check
        $error("header length field does not fit in DATA_W");
    end

    in_st_e           in_st_q   [3];
    in_st_e           in_st_d   [3];
    logic [LEN_W-1:0] in_rem_q  [3];
    logic [LEN_W-1:0] in_rem_d  [3];
    out_st_e          out_st_q  [3];
    out_st_e          out_st_d  [3];
    logic [1:0]       out_src_q [3];
    logic [1:0]       out_src_d [3];
    logic [LEN_W-1:0] out_rem_q [3];
    logic [LEN_W-1:0] out_rem_d [3];
    logic [1:0]       ptr_q     [3];
    logic [1:0]       ptr_d     [3];
    logic [2:0]       pkt_done_q, pkt_done_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [1:0]       hd_dest [3];
    logic [LEN_W-1:0] hd_len  [3];
    logic [2:0]       req     [3];
    logic [2:0]       fifo_rd;
    logic [2:0]       out_wr;
    logic [1:0]       mux_sel [3];

    // Header fields at each FIFO head; only meaningful while the input is IDLE.
    always_comb begin
        hd_dest[0] = bus.fifo_q1[1:0];
        hd_dest[1] = bus.fifo_q2[1:0];
        hd_dest[2] = bus.fifo_q3[1:0];
        hd_len[0]  = bus.fifo_q1[LEN_LSB +: LEN_W];
        hd_len[1]  = bus.fifo_q2[LEN_LSB +: LEN_W];
        hd_len[2]  = bus.fifo_q3[LEN_LSB +: LEN_W];
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                req[o][i] = (in_st_q[i] == IN_IDLE) && !bus.fifo_empty[i] &&
                            (hd_dest[i] == 2'(o + 1));
            end
        end
    end

    always_comb begin : p_next
        logic [1:0] src_idx;
        logic [1:0] cand;
        logic       granted;

        in_st_d    = in_st_q;
        in_rem_d   = in_rem_q;
        out_st_d   = out_st_q;
        out_src_d  = out_src_q;
        out_rem_d  = out_rem_q;
        ptr_d      = ptr_q;
        pkt_done_d = '0;
        drop_cnt_d = drop_cnt_q;
        fifo_rd    = '0;
        out_wr     = '0;
        src_idx    = '0;
        cand       = '0;
        granted    = 1'b0;
        for (int o = 0; o < 3; o++) begin
            mux_sel[o] = '0;
        end

        for (int o = 0; o < 3; o++) begin
            if (out_st_q[o] == OUT_BUSY) begin
                src_idx    = out_src_q[o] - 2'd1;
                mux_sel[o] = out_src_q[o];
                if (!bus.fifo_empty[src_idx] && !bus.out_full[o]) begin
                    fifo_rd[src_idx] = 1'b1;
                    out_wr[o]        = 1'b1;
                    if (out_rem_q[o] == '0) begin
                        out_st_d[o]      = OUT_IDLE;
                        in_st_d[src_idx] = IN_IDLE;
                        pkt_done_d[o]    = 1'b1;
                    end else begin
                        out_rem_d[o] = out_rem_q[o] - 1'b1;
                    end
                end
            end else begin
                // Scan starts just after the last winner, wrapping 3 -> 1.
                granted = 1'b0;
                cand    = (ptr_q[o] == 2'd3) ? 2'd0 : ptr_q[o];
                for (int k = 0; k < 3; k++) begin
                    if (!granted && req[o][cand]) begin
                        granted       = 1'b1;
                        out_st_d[o]   = OUT_BUSY;
                        out_src_d[o]  = cand + 2'd1;
                        out_rem_d[o]  = hd_len[cand];
                        in_st_d[cand] = IN_FWD;
                        ptr_d[o]      = cand + 2'd1;
                    end
                    cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
                end
            end
        end

        // Dropped packets are popped word by word with no output involvement.
        for (int i = 0; i < 3; i++) begin
            if (in_st_q[i] == IN_IDLE && !bus.fifo_empty[i] && hd_dest[i] == 2'd0) begin
                in_st_d[i]  = IN_DROP;
                in_rem_d[i] = hd_len[i];
            end else if (in_st_q[i] == IN_DROP && !bus.fifo_empty[i]) begin
                fifo_rd[i] = 1'b1;
                if (in_rem_q[i] == '0) begin
                    in_st_d[i] = IN_IDLE;
                    if (drop_cnt_d != 8'hFF) begin
                        drop_cnt_d = drop_cnt_d + 8'd1;
                    end
                end else begin
                    in_rem_d[i] = in_rem_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                in_st_q[i]   <= IN_IDLE;
                in_rem_q[i]  <= '0;
                out_st_q[i]  <= OUT_IDLE;
                out_src_q[i] <= '0;
                out_rem_q[i] <= '0;
                ptr_q[i]     <= 2'd3;
            end
            pkt_done_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_st_q    <= in_st_d;
            in_rem_q   <= in_rem_d;
            out_st_q   <= out_st_d;
            out_src_q  <= out_src_d;
            out_rem_q  <= out_rem_d;
            ptr_q      <= ptr_d;
            pkt_done_q <= pkt_done_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.fifo_rd  = fifo_rd;
    assign bus.out_wr   = out_wr;
    assign bus.mux_sel1 = mux_sel[0];
    assign bus.mux_sel2 = mux_sel[1];
    assign bus.mux_sel3 = mux_sel[2];
    assign bus.pkt_done = pkt_done_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed bench for crossbar_arbiter: FIFO model with show-ahead heads, per-output write log checked against expected words.
module tb_crossbar_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    crossbar_arbiter_if #(.DATA_W(32)) xif ();

    crossbar_arbiter #(.DATA_W(32), .LEN_LSB(2), .LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (xif)
    );

    typedef struct {
        int         src;
        logic [1:0] dst;
        logic [3:0] n;
        logic [2:0] exp_rd;
        logic [2:0] exp_wr;
        logic [1:0] exp_sel;
        logic [2:0] exp_done;
    } vec_t;

    vec_t        vt [4];
    logic [31:0] fq   [3][$];
    logic [31:0] olog [3][$];
    logic [31:0] elog [3][$];
    logic [2:0]  s_rd, s_wr, s_done;
    logic [1:0]  s_sel [3];
    logic [7:0]  s_drop;
    logic [2:0]  rr_rd   [8];
    logic [1:0]  rr_sel  [8];
    logic [2:0]  rr_done [8];
    logic [2:0]  any_wr;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] hdr(input logic [1:0] dst, input logic [3:0] n, input logic [7:0] tag);
        return {tag, 16'h0000, 2'b00, n, dst};
    endfunction

    function automatic logic [31:0] pay(input logic [7:0] tag, input logic [7:0] idx);
        return {tag, 8'h5A, 8'hA5, idx};
    endfunction

    // An empty FIFO presents a word that would look like a dest-3 header if the arbiter ignored fifo_empty.
    function automatic logic [31:0] head_of(input int i);
        if (fq[i].size() == 0) return 32'hFFFF_FFFF;
        return fq[i][0];
    endfunction

    task automatic refresh();
        logic [2:0] e;
        for (int i = 0; i < 3; i++) e[i] = (fq[i].size() == 0);
        xif.fifo_empty = e;
        xif.fifo_q1    = head_of(0);
        xif.fifo_q2    = head_of(1);
        xif.fifo_q3    = head_of(2);
    endtask

    task automatic push(input int i, input logic [31:0] w, input int o);
        fq[i].push_back(w);
        if (o >= 0) elog[o].push_back(w);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, then apply pops just after the rising edge.
    task automatic tick();
        logic [31:0] hd [3];
        @(negedge clk);
        for (int i = 0; i < 3; i++) hd[i] = head_of(i);
        s_rd     = xif.fifo_rd;
        s_wr     = xif.out_wr;
        s_done   = xif.pkt_done;
        s_drop   = xif.drop_cnt;
        s_sel[0] = xif.mux_sel1;
        s_sel[1] = xif.mux_sel2;
        s_sel[2] = xif.mux_sel3;
        for (int o = 0; o < 3; o++) begin
            if (s_wr[o]) olog[o].push_back(s_sel[o] == 2'd0 ? 32'h0 : hd[int'(s_sel[o]) - 1]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (s_rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            olog[i].delete();
            elog[i].delete();
        end
        xif.out_full = 3'b000;
        refresh();
        @(posedge clk);
        #1;
        chk("reset fifo_rd", xif.fifo_rd, 3'b000);
        chk("reset out_wr", xif.out_wr, 3'b000);
        chk("reset mux_sel", {xif.mux_sel1, xif.mux_sel2, xif.mux_sel3}, 6'b0);
        chk("reset pkt_done", xif.pkt_done, 3'b000);
        chk("reset drop_cnt", xif.drop_cnt, 8'd0);
    endtask

    task automatic release_reset();
        refresh();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk_logs(input string nm);
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("%s out%0d word count", nm, o + 1), olog[o].size(), elog[o].size());
            for (int k = 0; k < elog[o].size() && k < olog[o].size(); k++) begin
                chk($sformatf("%s out%0d word %0d", nm, o + 1, k), olog[o][k], elog[o][k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1, 2'd2, 4'd2,  3'b001, 3'b010, 2'd1, 3'b010};
        vt[1] = '{2, 2'd3, 4'd0,  3'b010, 3'b100, 2'd2, 3'b100};
        vt[2] = '{3, 2'd1, 4'd3,  3'b100, 3'b001, 2'd3, 3'b001};
        vt[3] = '{2, 2'd1, 4'd15, 3'b010, 3'b001, 2'd2, 3'b001};
        rr_rd   = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100};
        rr_sel  = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
        rr_done = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
        xif.out_full = 3'b000;
        refresh();

        // Single packets from the vector table.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push(vt[v].src - 1, hdr(vt[v].dst, vt[v].n, 8'(8'h10 + v)), int'(vt[v].dst) - 1);
            for (int k = 0; k < int'(vt[v].n); k++) push(vt[v].src - 1, pay(8'(8'h20 + v), 8'(k)), int'(vt[v].dst) - 1);
            release_reset();
            tick();
            chk($sformatf("v%0d c0 rd", v), s_rd, 3'b000);
            chk($sformatf("v%0d c0 wr", v), s_wr, 3'b000);
            for (int c = 1; c <= int'(vt[v].n) + 1; c++) begin
                tick();
                chk($sformatf("v%0d c%0d rd", v, c), s_rd, vt[v].exp_rd);
                chk($sformatf("v%0d c%0d wr", v, c), s_wr, vt[v].exp_wr);
                chk($sformatf("v%0d c%0d sel", v, c), s_sel[int'(vt[v].dst) - 1], vt[v].exp_sel);
                chk($sformatf("v%0d c%0d done", v, c), s_done, 3'b000);
            end
            tick();
            chk($sformatf("v%0d end done", v), s_done, vt[v].exp_done);
            chk($sformatf("v%0d end wr", v), s_wr, 3'b000);
            chk($sformatf("v%0d end sel", v), s_sel[int'(vt[v].dst) - 1], 2'd0);
            chk_logs($sformatf("v%0d", v));
        end

        // Round-robin on output 1: 1 then 3, reload both, 1 then 3 again.
        do_reset();
        push(0, hdr(2'd1, 4'd0, 8'hC1), 0);
        push(2, hdr(2'd1, 4'd0, 8'hC3), 0);
        release_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr c%0d rd", c), s_rd, rr_rd[c]);
            chk($sformatf("rr c%0d sel1", c), s_sel[0], rr_sel[c]);
            chk($sformatf("rr c%0d done", c), s_done, rr_done[c]);
            if (c == 3) begin
                push(0, hdr(2'd1, 4'd0, 8'hD1), 0);
                push(2, hdr(2'd1, 4'd0, 8'hD3), 0);
                refresh();
            end
        end
        chk_logs("rr");

        // Three outputs in parallel.
        do_reset();
        push(0, hdr(2'd3, 4'd3, 8'h31), 2);
        push(1, hdr(2'd1, 4'd3, 8'h32), 0);
        push(2, hdr(2'd2, 4'd3, 8'h33), 1);
        for (int k = 0; k < 3; k++) begin
            push(0, pay(8'h41, 8'(k)), 2);
            push(1, pay(8'h42, 8'(k)), 0);
            push(2, pay(8'h43, 8'(k)), 1);
        end
        release_reset();
        tick();
        chk("par c0 wr", s_wr, 3'b000);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("par c%0d rd", c), s_rd, 3'b111);
            chk($sformatf("par c%0d wr", c), s_wr, 3'b111);
            chk($sformatf("par c%0d sels", c), {s_sel[0], s_sel[1], s_sel[2]}, {2'd2, 2'd3, 2'd1});
        end
        tick();
        chk("par done", s_done, 3'b111);
        chk("par end wr", s_wr, 3'b000);
        chk_logs("par");

        // Output-full stall for 3 cycles, then FIFO underflow stall, then completion.
        do_reset();
        push(0, hdr(2'd1, 4'd4, 8'hB0), 0);
        push(0, pay(8'hB1, 8'd0), 0);
        push(0, pay(8'hB1, 8'd1), 0);
        release_reset();
        tick();
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk($sformatf("bp c%0d wr", c), s_wr, 3'b001);
        end
        xif.out_full = 3'b001;
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk($sformatf("bp full c%0d rd", c), s_rd, 3'b000);
            chk($sformatf("bp full c%0d wr", c), s_wr, 3'b000);
            chk($sformatf("bp full c%0d sel1", c), s_sel[0], 2'd1);
        end
        xif.out_full = 3'b000;
        tick();
        chk("bp c6 rd", s_rd, 3'b001);
        tick();
        chk("bp empty c7 rd", s_rd, 3'b000);
        chk("bp empty c7 wr", s_wr, 3'b000);
        chk("bp empty c7 sel1", s_sel[0], 2'd1);
        chk("bp empty c7 done", s_done, 3'b000);
        push(0, pay(8'hB1, 8'd2), 0);
        push(0, pay(8'hB1, 8'd3), 0);
        refresh();
        tick();
        tick();
        chk("bp c9 wr", s_wr, 3'b001);
        chk("bp c9 done", s_done, 3'b000);
        tick();
        chk("bp done", s_done, 3'b001);
        chk_logs("bp");

        // Drop N=5, then saturate the drop counter.
        do_reset();
        push(1, hdr(2'd0, 4'd5, 8'hE0), -1);
        for (int k = 0; k < 5; k++) push(1, pay(8'hE1, 8'(k)), -1);
        release_reset();
        tick();
        chk("drop c0 rd", s_rd, 3'b000);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("drop c%0d rd", c), s_rd, 3'b010);
            chk($sformatf("drop c%0d wr", c), s_wr, 3'b000);
        end
        chk("drop cnt before", s_drop, 8'd0);
        tick();
        chk("drop c7 rd", s_rd, 3'b000);
        chk("drop cnt after", s_drop, 8'd1);
        for (int k = 0; k < 299; k++) push(1, hdr(2'd0, 4'd0, 8'(k)), -1);
        refresh();
        any_wr = 3'b000;
        for (int c = 0; c < 604; c++) begin
            tick();
            any_wr = any_wr | s_wr;
        end
        chk("drop sat cnt", s_drop, 8'd255);
        chk("drop fifo drained", fq[1].size(), 0);
        chk("drop no writes", any_wr, 3'b000);
        chk_logs("drop");

        // Reset in the middle of a N=4 packet; the next head word is a header.
        do_reset();
        push(0, hdr(2'd2, 4'd4, 8'hF0), 1);
        push(0, pay(8'hF1, 8'd0), 1);
        push(0, hdr(2'd3, 4'd2, 8'hF2), 2);
        push(0, pay(8'hF3, 8'd0), 2);
        push(0, pay(8'hF3, 8'd1), 2);
        release_reset();
        tick();
        tick();
        tick();
        #2;
        chk("mid before rst rd", xif.fifo_rd, 3'b001);
        chk("mid before rst sel2", xif.mux_sel2, 2'd1);
        reset = 1'b1;
        #1;
        chk("mid rst rd", xif.fifo_rd, 3'b000);
        chk("mid rst wr", xif.out_wr, 3'b000);
        chk("mid rst sels", {xif.mux_sel1, xif.mux_sel2, xif.mux_sel3}, 6'b0);
        chk("mid rst done", xif.pkt_done, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("mid c0 rd", s_rd, 3'b000);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("mid c%0d rd", c), s_rd, 3'b001);
            chk($sformatf("mid c%0d wr", c), s_wr, 3'b100);
            chk($sformatf("mid c%0d sel3", c), s_sel[2], 2'd1);
            chk($sformatf("mid c%0d sel2", c), s_sel[1], 2'd0);
        end
        tick();
        chk("mid done", s_done, 3'b100);
        chk_logs("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
